// File: rtl/udp_mem_gateway.sv
// udp_mem_gateway: UDP payload to local-bus read/write master with echo reply.
// Ports: clk, rst (sync, active high); idata/raw_s payload stream in;
//   odata reply byte out (n_lat cycles later); lb_addr/lb_wdata/lb_write/
//   lb_read local-bus master; lb_rdata read data (rd_lat after lb_read).
// Optional: define MEM_GW_WR_COUNT_EN to add the wr_count[15:0] output.
module udp_mem_gateway #(
    parameter int n_lat  = 3,
    parameter int rd_lat = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  idata,
    input  logic        raw_s,
    output logic [7:0]  odata,
    output logic [23:0] lb_addr,
    output logic [31:0] lb_wdata,
    output logic        lb_write,
    output logic        lb_read,
    input  logic [31:0] lb_rdata
`ifdef MEM_GW_WR_COUNT_EN
    ,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [1:0] {DRAIN, IDLE, HDR, XACT} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        is_rd;
    logic [23:0] addr_r;
    logic [23:0] wd_r;
    logic        in_x, rd_req, wr_req;
    logic        v_in, sub_in;

    logic [rd_lat-1:0] rd_sr;
    logic              rd_valid;
    logic [31:0]       rdata_r, rd_now;
    logic [7:0]        rd_byte;

    // Delay line; stage n_lat-2 feeds the odata register.
    logic [7:0]       dl_byte [n_lat-1];
    logic [1:0]       dl_idx  [n_lat-1];
    logic [n_lat-2:0] dl_v;
    logic [n_lat-2:0] dl_sub;

    assign in_x   = (state == XACT) && raw_s;
    assign rd_req = in_x && (cnt == 3'd3) && is_rd;
    assign wr_req = in_x && (cnt == 3'd7) && !is_rd;
    assign v_in   = raw_s && (state != DRAIN);
    // Data bytes of a read are replaced by the captured read word.
    assign sub_in = in_x && cnt[2] && is_rd;

    assign rd_valid = rd_sr[rd_lat-1];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            DRAIN: if (!raw_s) state_nx = IDLE;
            IDLE: begin
                if (raw_s) begin
                    state_nx = HDR;
                    cnt_nx   = 3'd1;
                end
            end
            HDR: begin
                if (!raw_s) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                    if (cnt == 3'd7) state_nx = XACT;
                end
            end
            XACT: begin
                if (!raw_s) state_nx = IDLE;
                else        cnt_nx   = cnt + 3'd1;
            end
        endcase
    end

    // When rd_lat = n_lat-1 the read word arrives in the same cycle the
    // first data byte is substituted, so bypass the capture register.
    always_comb begin
        rd_now = rd_valid ? lb_rdata : rdata_r;
        unique case (dl_idx[n_lat-2])
            2'd0: rd_byte = rd_now[31:24];
            2'd1: rd_byte = rd_now[23:16];
            2'd2: rd_byte = rd_now[15:8];
            2'd3: rd_byte = rd_now[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DRAIN;
            cnt      <= 3'd0;
            is_rd    <= 1'b0;
            addr_r   <= '0;
            wd_r     <= '0;
            lb_addr  <= '0;
            lb_wdata <= '0;
            lb_write <= 1'b0;
            lb_read  <= 1'b0;
            rd_sr    <= '0;
            rdata_r  <= '0;
            odata    <= 8'h00;
            dl_v     <= '0;
            dl_sub   <= '0;
            for (int k = 0; k < n_lat - 1; k++) begin
                dl_byte[k] <= 8'h00;
                dl_idx[k]  <= 2'd0;
            end
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            lb_read  <= rd_req;
            lb_write <= wr_req;

            if (in_x) begin
                unique case (cnt)
                    3'd0:             is_rd  <= idata[4];
                    3'd1, 3'd2, 3'd3: addr_r <= {addr_r[15:0], idata};
                    3'd4, 3'd5, 3'd6: wd_r   <= {wd_r[15:0], idata};
                    default: ;
                endcase
            end

            if (rd_req) lb_addr <= {addr_r[15:0], idata};
            if (wr_req) begin
                lb_addr  <= addr_r;
                lb_wdata <= {wd_r, idata};
            end

            rd_sr[0] <= lb_read;
            for (int k = 1; k < rd_lat; k++) rd_sr[k] <= rd_sr[k-1];
            if (rd_valid) rdata_r <= lb_rdata;

            dl_byte[0] <= idata;
            dl_idx[0]  <= cnt[1:0];
            dl_v[0]    <= v_in;
            dl_sub[0]  <= sub_in;
            for (int k = 1; k < n_lat - 1; k++) begin
                dl_byte[k] <= dl_byte[k-1];
                dl_idx[k]  <= dl_idx[k-1];
                dl_v[k]    <= dl_v[k-1];
                dl_sub[k]  <= dl_sub[k-1];
            end

            if (!dl_v[n_lat-2])       odata <= 8'h00;
            else if (dl_sub[n_lat-2]) odata <= rd_byte;
            else                      odata <= dl_byte[n_lat-2];
        end
    end

`ifdef MEM_GW_WR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)           wr_count <= 16'h0000;
        else if (lb_write) wr_count <= wr_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_udp_mem_gateway.sv
// tb_udp_mem_gateway: cycle-table bench for udp_mem_gateway.
// Ports: drives clk, rst, idata, raw_s, lb_rdata; checks odata and bus.
module tb_udp_mem_gateway;

    localparam int NV = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  idata;
    logic        raw_s;
    logic [7:0]  odata;
    logic [23:0] lb_addr;
    logic [31:0] lb_wdata;
    logic        lb_write;
    logic        lb_read;
    logic [31:0] lb_rdata;
`ifdef MEM_GW_WR_COUNT_EN
    logic [15:0] wr_count;
`endif

    udp_mem_gateway #(.n_lat(3), .rd_lat(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .idata    (idata),
        .raw_s    (raw_s),
        .odata    (odata),
        .lb_addr  (lb_addr),
        .lb_wdata (lb_wdata),
        .lb_write (lb_write),
        .lb_read  (lb_read),
        .lb_rdata (lb_rdata)
`ifdef MEM_GW_WR_COUNT_EN
        ,
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        raw;
        logic [7:0]  din;
        logic [31:0] rdata;
        logic [7:0]  eo;
        logic        ewr;
        logic        erd;
        logic        ca;
        logic [23:0] ea;
        logic        cw;
        logic [31:0] ewd;
    } vec_t;

    vec_t       v [NV];
    int         n;
    logic [7:0] pb [24];
    int         errors;
    int         checks;

    task automatic chk(input string nm, input int row,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, got, want);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            v[n].raw = 1'b0;
            n++;
        end
    endtask

    task automatic hdr();
        for (int i = 0; i < 8; i++) pb[i] = 8'(i + 1);
    endtask

    task automatic txn(input int x, input logic [7:0] c,
                       input logic [23:0] a, input logic [31:0] d);
        pb[8+8*x]  = c;
        pb[9+8*x]  = a[23:16];
        pb[10+8*x] = a[15:8];
        pb[11+8*x] = a[7:0];
        pb[12+8*x] = d[31:24];
        pb[13+8*x] = d[23:16];
        pb[14+8*x] = d[15:8];
        pb[15+8*x] = d[7:0];
    endtask

    // Pushes a packet; bytes echo 3 rows later unless cut off by reset.
    task automatic add_pkt(input int len, input int rst_at,
                           output int s);
        s = n;
        for (int k = 0; k < len; k++) begin
            v[n].raw = 1'b1;
            v[n].din = pb[k];
            v[n].rst = (k == rst_at);
            n++;
        end
        for (int k = 0; k < len; k++)
            if (rst_at < 0 || k + 3 <= rst_at)
                v[s+k+3].eo = pb[k];
        if (rst_at >= 0) begin
            v[s+rst_at+1].ca  = 1'b1;
            v[s+rst_at+1].ea  = 24'h0;
            v[s+rst_at+1].cw  = 1'b1;
            v[s+rst_at+1].ewd = 32'h0;
        end
    endtask

    task automatic add_write(input int s, input int x,
                             input logic [23:0] a,
                             input logic [31:0] d);
        int t;
        t = s + 15 + 8 * x;
        v[t+1].ewr = 1'b1;
        v[t+1].ca  = 1'b1;
        v[t+1].ea  = a;
        v[t+1].cw  = 1'b1;
        v[t+1].ewd = d;
    endtask

    task automatic add_read(input int s, input int x,
                            input logic [23:0] a,
                            input logic [31:0] d, input int nd);
        int t;
        t = s + 11 + 8 * x;
        v[t+1].erd   = 1'b1;
        v[t+1].ca    = 1'b1;
        v[t+1].ea    = a;
        v[t+2].rdata = d;
        for (int k = 0; k < nd; k++)
            v[t+4+k].eo = d[31-8*k -: 8];
    endtask

    int s1, s2, s3, s4, s5, s6, s7;

    initial begin
        errors = 0;
        checks = 0;
        n      = 0;
        for (int i = 0; i < NV; i++) begin
            v[i].rst   = 1'b0;
            v[i].raw   = 1'b0;
            v[i].din   = 8'h5A;
            v[i].rdata = 32'h0BAD0BAD;
            v[i].eo    = 8'h00;
            v[i].ewr   = 1'b0;
            v[i].erd   = 1'b0;
            v[i].ca    = 1'b0;
            v[i].ea    = 24'h0;
            v[i].cw    = 1'b0;
            v[i].ewd   = 32'h0;
        end
        for (int i = 0; i < 24; i++) pb[i] = 8'h00;

        // reset state visible in row 0
        v[0].ca = 1'b1;
        v[0].cw = 1'b1;
        idle(2);

        hdr();
        txn(0, 8'h00, 24'h000010, 32'hDEADBEEF);
        add_pkt(16, -1, s1);
        add_write(s1, 0, 24'h000010, 32'hDEADBEEF);
        idle(4);

        txn(0, 8'h10, 24'h000020, 32'h00000000);
        add_pkt(16, -1, s2);
        add_read(s2, 0, 24'h000020, 32'hCAFEF00D, 4);
        idle(4);

        txn(0, 8'h00, 24'h000001, 32'h11111111);
        txn(1, 8'h91, 24'h000001, 32'hAABBCCDD);
        add_pkt(24, -1, s3);
        add_write(s3, 0, 24'h000001, 32'h11111111);
        add_read(s3, 1, 24'h000001, 32'h11111111, 4);
        idle(4);

        txn(0, 8'h00, 24'h000030, 32'h55667788);
        add_pkt(13, -1, s4);
        idle(4);

        txn(0, 8'h10, 24'h000040, 32'h0);
        txn(1, 8'h00, 24'h000050, 32'h99999999);
        add_pkt(24, 10, s5);
        idle(4);

        txn(0, 8'h00, 24'h000060, 32'h12345678);
        add_pkt(16, -1, s6);
        add_write(s6, 0, 24'h000060, 32'h12345678);
        idle(4);

        txn(0, 8'h10, 24'h000070, 32'h0);
        add_pkt(12, -1, s7);
        add_read(s7, 0, 24'h000070, 32'h76543210, 0);
        idle(6);

        rst      = 1'b1;
        raw_s    = 1'b0;
        idata    = 8'h00;
        lb_rdata = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst      = v[i].rst;
            raw_s    = v[i].raw;
            idata    = v[i].din;
            lb_rdata = v[i].rdata;
            @(negedge clk);
            chk("odata", i, 32'(odata), 32'(v[i].eo));
            chk("lb_write", i, 32'(lb_write), 32'(v[i].ewr));
            chk("lb_read", i, 32'(lb_read), 32'(v[i].erd));
            if (v[i].ca)
                chk("lb_addr", i, 32'(lb_addr), 32'(v[i].ea));
            if (v[i].cw)
                chk("lb_wdata", i, lb_wdata, v[i].ewd);
`ifdef MEM_GW_WR_COUNT_EN
            if (i == s5)
                chk("wr_count", i, 32'(wr_count), 32'd2);
            if (i == n - 1)
                chk("wr_count", i, 32'(wr_count), 32'd1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
